// File: rtl/mvm_uart_tx.sv
// Word-level UART transmitter: splits a W_Y_OUT-bit word into BITS_PER_WORD-bit
// bytes (LSB byte first) and sends each as a start/data/stop frame on tx.
module mvm_uart_tx #(
  parameter int CLOCKS_PER_PULSE = 4,
  parameter int BITS_PER_WORD    = 8,
  parameter int PACKET_SIZE_TX   = 13,
  parameter int W_Y_OUT          = 16
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic [W_Y_OUT-1:0] s_data,
  input  logic               s_valid,
  output logic               s_ready,
  output logic               tx,
  output logic               busy
);
  localparam int NBYTES = W_Y_OUT / BITS_PER_WORD;
  localparam int NSTOP  = PACKET_SIZE_TX - BITS_PER_WORD - 1;
  localparam int PCW    = (CLOCKS_PER_PULSE > 1) ? $clog2(CLOCKS_PER_PULSE) : 1;
  localparam int BCW    = $clog2(PACKET_SIZE_TX);
  localparam int YCW    = (NBYTES > 1) ? $clog2(NBYTES) : 1;

  localparam logic [PCW-1:0] P_LAST = PCW'(CLOCKS_PER_PULSE - 1);
  localparam logic [BCW-1:0] B_LAST = BCW'(PACKET_SIZE_TX - 1);
  localparam logic [YCW-1:0] Y_LAST = YCW'(NBYTES - 1);

  typedef enum logic {IDLE, SEND} state_t;

  state_t             state, state_n;
  logic [W_Y_OUT-1:0] sreg, sreg_n;
  logic [PCW-1:0]     pcnt, pcnt_n;
  logic [BCW-1:0]     bcnt, bcnt_n;
  logic [YCW-1:0]     ycnt, ycnt_n;
  logic               tx_n, ready_n, busy_n;
  logic [PACKET_SIZE_TX-1:0] frame;
  logic               accept, last;

  assign accept = (state == IDLE) && s_valid && s_ready;
  assign last   = (state == SEND) && (pcnt == P_LAST) && (bcnt == B_LAST) && (ycnt == Y_LAST);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state   <= IDLE;
      sreg    <= '0;
      pcnt    <= '0;
      bcnt    <= '0;
      ycnt    <= '0;
      tx      <= 1'b1;
      s_ready <= 1'b0;
      busy    <= 1'b0;
    end else begin
      state   <= state_n;
      sreg    <= sreg_n;
      pcnt    <= pcnt_n;
      bcnt    <= bcnt_n;
      ycnt    <= ycnt_n;
      tx      <= tx_n;
      s_ready <= ready_n;
      busy    <= busy_n;
    end
  end

  always_comb begin
    state_n = state;
    if (accept)    state_n = SEND;
    else if (last) state_n = IDLE;
  end

  // Outputs are registered, so tx is computed from the counter values the
  // next cycle will hold; that way tx drops in the very cycle after accept.
  always_comb begin
    sreg_n  = sreg;
    pcnt_n  = pcnt;
    bcnt_n  = bcnt;
    ycnt_n  = ycnt;
    tx_n    = 1'b1;
    ready_n = 1'b0;
    busy_n  = 1'b0;
    if (state == IDLE) begin
      ready_n = 1'b1;
      if (accept) begin
        sreg_n  = s_data;
        pcnt_n  = '0;
        bcnt_n  = '0;
        ycnt_n  = '0;
        ready_n = 1'b0;
        busy_n  = 1'b1;
      end
    end else if (!last) begin
      busy_n = 1'b1;
      if (pcnt == P_LAST) begin
        pcnt_n = '0;
        if (bcnt == B_LAST) begin
          bcnt_n = '0;
          ycnt_n = ycnt + 1'b1;
          sreg_n = sreg >> BITS_PER_WORD;
        end else begin
          bcnt_n = bcnt + 1'b1;
        end
      end else begin
        pcnt_n = pcnt + 1'b1;
      end
    end else begin
      ready_n = 1'b1;
    end
    frame = {{NSTOP{1'b1}}, sreg_n[BITS_PER_WORD-1:0], 1'b0};
    if (busy_n) tx_n = frame[bcnt_n];
  end
endmodule

// File: tb/tb_mvm_uart_tx.sv
// Directed bench for mvm_uart_tx: default instance plus a CLOCKS_PER_PULSE=1,
// W_Y_OUT=8 instance sharing clock and reset.
module tb_mvm_uart_tx;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [15:0] s_data;
  logic        s_valid, s_ready, tx, busy;
  logic [7:0]  v_data;
  logic        v_valid, v_ready, v_tx, v_busy;
  int          total = 0;
  int          bad = 0;
  logic        cap [0:103];
  logic [0:12] vseq;

  mvm_uart_tx dut (
    .clk(clk), .rstn(rstn), .s_data(s_data), .s_valid(s_valid),
    .s_ready(s_ready), .tx(tx), .busy(busy)
  );

  mvm_uart_tx #(.CLOCKS_PER_PULSE(1), .BITS_PER_WORD(8), .PACKET_SIZE_TX(13), .W_Y_OUT(8)) vdut (
    .clk(clk), .rstn(rstn), .s_data(v_data), .s_valid(v_valid),
    .s_ready(v_ready), .tx(v_tx), .busy(v_busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Expected line level for cycle k (0..103) of a default-parameter word.
  function automatic logic exp_bit(input logic [15:0] w, input int k);
    int b, p;
    b = k / 52;
    p = (k % 52) / 4;
    if (p == 0) return 1'b0;
    if (p <= 8) return w[b*8 + p - 1];
    return 1'b1;
  endfunction

  // Entered at a negedge with s_ready=1; leaves at the negedge of cycle E+105.
  task automatic run_word(input string tag, input logic [15:0] w, input bit keep, input bit poke);
    int nb = 0;
    int nerr = 0;
    int nrdy = 0;
    logic [7:0] d0, d1;
    s_data  = w;
    s_valid = 1'b1;
    @(negedge clk);
    if (!keep) s_valid = 1'b0;
    for (int k = 0; k < 104; k++) begin
      cap[k] = tx;
      if (busy) nb++;
      if (s_ready) nrdy++;
      if (tx !== exp_bit(w, k)) nerr++;
      if (poke) begin
        if (k >= 10 && k < 40) begin
          s_data  = 16'h1234;
          s_valid = k[0];
        end else begin
          s_valid = 1'b0;
        end
      end
      if (k < 103) @(negedge clk);
    end
    for (int i = 0; i < 8; i++) begin
      d0[i] = cap[(1 + i) * 4 + 2];
      d1[i] = cap[52 + (1 + i) * 4 + 2];
    end
    chk($sformatf("%s_bits", tag), nerr, 0);
    chk($sformatf("%s_busy_cycles", tag), nb, 104);
    chk($sformatf("%s_ready_low", tag), nrdy, 0);
    chk($sformatf("%s_byte0", tag), d0, w[7:0]);
    chk($sformatf("%s_byte1", tag), d1, w[15:8]);
    @(negedge clk);
    chk($sformatf("%s_end_ready", tag), s_ready, 1);
    chk($sformatf("%s_end_busy", tag), busy, 0);
    chk($sformatf("%s_end_tx", tag), tx, 1);
  endtask

  initial begin
    s_data  = '0;
    s_valid = 1'b0;
    v_data  = '0;
    v_valid = 1'b0;
    vseq    = 13'b0100000011111;

    rstn = 1'b0;
    repeat (3) begin
      @(negedge clk);
      chk("rst_tx", tx, 1);
      chk("rst_ready", s_ready, 0);
      chk("rst_busy", busy, 0);
    end
    rstn = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", s_ready, 1);
    chk("post_rst_tx", tx, 1);
    chk("post_rst_busy", busy, 0);
    chk("post_rst_v_ready", v_ready, 1);

    run_word("w_a53c", 16'hA53C, 1'b0, 1'b0);

    // s_valid stays high across the pair; second accept lands at E+105.
    run_word("b2b_0000", 16'h0000, 1'b1, 1'b0);
    run_word("b2b_ffff", 16'hFFFF, 1'b0, 1'b0);

    run_word("ignore", 16'hC35A, 1'b0, 1'b1);

    s_data  = 16'h0000;
    s_valid = 1'b1;
    @(negedge clk);
    s_valid = 1'b0;
    repeat (29) @(negedge clk);
    chk("mid_pre_tx", tx, 0);
    rstn = 1'b0;
    #1;
    chk("mid_rst_tx", tx, 1);
    chk("mid_rst_ready", s_ready, 0);
    chk("mid_rst_busy", busy, 0);
    @(negedge clk);
    @(negedge clk);
    chk("mid_hold_tx", tx, 1);
    rstn = 1'b1;
    @(negedge clk);
    chk("mid_rel_ready", s_ready, 1);
    chk("mid_rel_busy", busy, 0);
    run_word("recover", 16'h00FF, 1'b0, 1'b0);

    v_data  = 8'h81;
    v_valid = 1'b1;
    @(negedge clk);
    v_valid = 1'b0;
    chk("v_ready_low", v_ready, 0);
    for (int k = 0; k < 13; k++) begin
      chk($sformatf("v_bit%0d", k), v_tx, vseq[k]);
      chk($sformatf("v_busy%0d", k), v_busy, 1);
      if (k < 12) @(negedge clk);
    end
    @(negedge clk);
    chk("v_end_ready", v_ready, 1);
    chk("v_end_busy", v_busy, 0);
    chk("v_end_tx", v_tx, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/mvm_uart_tx.md
# mvm_uart_tx

Word-level UART transmitter for the MVM UART system. Accepts one `W_Y_OUT`-bit result word from the MVM datapath over a valid/ready handshake. Splits the word into `BITS_PER_WORD`-bit bytes, least-significant byte first, and serializes each byte as one `PACKET_SIZE_TX`-bit frame on `tx`. It is the transmit-side counterpart of the system's UART receiver and sits between the MVM output stage and the `tx` pin.

## Interface

**Parameters**
- `CLOCKS_PER_PULSE`, default 4: clock cycles per UART bit; must be ≥ 1.
- `BITS_PER_WORD`, default 8: data bits per frame.
- `PACKET_SIZE_TX`, default 13: total bits per frame (1 start + `BITS_PER_WORD` data + stop bits); must be ≥ `BITS_PER_WORD` + 2.
- `W_Y_OUT`, default 16: input word width; must be an integer multiple of `BITS_PER_WORD`.

**Ports**
- `clk` input, 1 bit: the single clock; all state updates on its rising edge.
- `rstn` input, 1 bit: asynchronous, active-low reset.
- `s_data` input, `W_Y_OUT` bits: word to transmit; sampled only on handshake.
- `s_valid` input, 1 bit: `s_data` is valid.
- `s_ready` output, 1 bit: registered; block can accept a word.
- `tx` output, 1 bit: registered serial line; idles high.
- `busy` output, 1 bit: registered; high while any frame of the current word is in flight.

## Operation

**Derived constants**
- `NBYTES` = `W_Y_OUT` / `BITS_PER_WORD`.
- `NSTOP` = `PACKET_SIZE_TX` − `BITS_PER_WORD` − 1 (4 with defaults).

**Frame format**
- Start bit: 0.
- `BITS_PER_WORD` data bits, LSB first.
- `NSTOP` stop bits: 1.
- Each bit is held for exactly `CLOCKS_PER_PULSE` cycles.

**State machine** (two states: IDLE, SEND)
- IDLE: `tx`=1, `s_ready`=1, `busy`=0.
- Handshake: `s_valid` & `s_ready` at a rising edge.
  - Latches `s_data` into a shift register.
  - Clears the pulse, bit and byte counters.
  - Moves to SEND with `s_ready`=0 and `busy`=1.
- SEND: the pulse counter runs 0..`CLOCKS_PER_PULSE`−1.
  - On pulse wrap, the bit counter advances 0..`PACKET_SIZE_TX`−1.
  - On bit wrap, the byte counter advances 0..`NBYTES`−1 and the shift register moves right by `BITS_PER_WORD`.
- `tx` value in SEND:
  - 0 when bit counter = 0.
  - Shift-register bit (bit counter − 1) when bit counter is 1..`BITS_PER_WORD`.
  - 1 otherwise.
- Frames within one word are back-to-back; there are no extra idle cycles between bytes.
- On the final pulse of the final stop bit of the final byte: return to IDLE, set `s_ready`=1 and `busy`=0.

**Boundary conditions**
- `s_valid` while `s_ready`=0: ignored. `s_data` changes have no effect on the word in flight.
- `s_valid` held high continuously: the next word is accepted on the first IDLE cycle. This gives exactly 1 idle-high cycle between words.
- `rstn` asserted mid-frame: immediately `tx`=1, `s_ready`=0, `busy`=0, and the state becomes IDLE. The partial word is dropped and is not resent.
- Reset values: `tx`=1, `s_ready`=0, `busy`=0. `s_ready` rises at the first rising edge after `rstn` deasserts.

## Timing

- Handshake at edge E: `tx` goes to 0 in the cycle after E.
- Word duration: `NBYTES` × `PACKET_SIZE_TX` × `CLOCKS_PER_PULSE` cycles, which is 104 with defaults. `tx` is driven by SEND for cycles E+1..E+104.
- `s_ready` and `busy` switch at the same edge that ends the last stop bit.
- Earliest next handshake: E+105, so the word period is 105 cycles.
- All outputs come straight from flops; there is no combinational path from inputs to outputs.

## Test plan

- **Reset:** hold `rstn`=0 for 3 cycles, then release. Required: `tx`=1, `s_ready`=0, `busy`=0 during reset; `s_ready`=1 one edge after release; `tx` stays 1.
- **Single word 0xA53C (defaults):**
  - `tx` low for 4 cycles (start bit).
  - Data bits 0,0,1,1,1,1,0,0, 4 cycles each.
  - 16 high cycles (stop bits).
  - Second frame with data bits 1,0,1,0,0,1,0,1.
  - `busy` high for exactly 104 cycles; receiver model decodes 0x3C then 0xA5.
- **Back-to-back words:** `s_valid` held high with 0x0000 then 0xFFFF. Required: second accept at E+105; exactly 1 idle-high cycle between words; decoded bytes are 0x00, 0x00, 0xFF, 0xFF.
- **Ignored input while busy:** change `s_data` to 0x1234 and toggle `s_valid` during SEND. Required: no accept, and the transmitted bytes are unchanged.
- **Reset mid-frame:** assert `rstn` at cycle 30 of a word. Required: `tx`=1 immediately. After release, new word 0x00FF transmits cleanly as 0xFF then 0x00.
- **Parameter variant:** `CLOCKS_PER_PULSE`=1, `W_Y_OUT`=8, word 0x81. Required: 13-cycle frame with bit sequence 0,1,0,0,0,0,0,0,1,1,1,1,1; `s_ready` back at E+14.
